pio_gen2: RTL and testbench

Parametrised second-generation Avalon-MM parallel I/O slave for the embedded CPU subsystem. Each bit can be an input or an output, and the output register supports set and clear strobes. Synchronised inputs feed per-bit edge capture with a maskable, level-sensitive interrupt to the CPU. It sits on the system interconnect beside the fixed 8-bit output-only PIO and replaces it where direction control or interrupts are needed.

---
 rtl/pio_gen2_if.sv | 19 +
 rtl/pio_gen2.sv | 113 +++++++++++
 tb/tb_pio_gen2.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pio_gen2_if.sv
// Avalon-MM slave bus bundle for pio_gen2: word address, chip select,
// active-low write strobe and 32-bit read/write data.
interface pio_gen2_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_gen2.sv
// Parametrised Avalon-MM parallel I/O slave: direction control, set/clear output
// strobes, synchronised inputs; edge capture + irq are built when PIO_GEN2_IRQ_EN is defined.
module pio_gen2 #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  pio_gen2_if.slave        bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;
  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [31:0]      rd_word;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign in_sync      = sync_p[SYNC_STAGES-1];

  // Pin synchroniser chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  // Output data and direction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_VALUE[WIDTH-1:0];
      dir_q <= '0;
    end else if (wr_en) begin
      case (bus.address)
        3'd0:    out_q <= wdata;
        3'd1:    dir_q <= wdata;
        3'd4:    out_q <= out_q | wdata;
        3'd5:    out_q <= out_q & ~wdata;
        default: ;
      endcase
    end
  end

  assign out_port = out_q;
  assign oe       = dir_q;

`ifdef PIO_GEN2_IRQ_EN
  logic [WIDTH-1:0] in_dly_p;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_mask;

  function automatic logic [WIDTH-1:0] detect_edge(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prev);
    case (EDGE_TYPE)
      0:       return cur & ~prev;
      1:       return ~cur & prev;
      default: return cur ^ prev;
    endcase
  endfunction

  assign edge_hit = detect_edge(in_sync, in_dly_p);
  assign clr_mask = (wr_en && bus.address == 3'd3) ? wdata : '0;

  // Edge detect delay, capture and mask; a fresh edge beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_dly_p  <= '0;
      edgecap_q <= '0;
      irqmask_q <= '0;
    end else begin
      in_dly_p  <= in_sync;
      edgecap_q <= (edgecap_q & ~clr_mask) | edge_hit;
      if (wr_en && bus.address == 3'd2) irqmask_q <= wdata;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);
`else
  assign irqmask_q = '0;
  assign edgecap_q = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (bus.address)
      3'd0:    rd_word[WIDTH-1:0] = (out_q & dir_q) | (in_sync & ~dir_q);
      3'd1:    rd_word[WIDTH-1:0] = dir_q;
      3'd2:    rd_word[WIDTH-1:0] = irqmask_q;
      3'd3:    rd_word[WIDTH-1:0] = edgecap_q;
      default: rd_word = '0;
    endcase
  end

  assign bus.readdata = rd_word;

endmodule

// File: tb/tb_pio_gen2.sv
// Directed bench for pio_gen2 (WIDTH=8, RESET_VALUE=A5, rising edges, 2 sync stages);
// expectations for edge capture/irq depend on whether PIO_GEN2_IRQ_EN is defined.
module tb_pio_gen2;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic [7:0] oe;
  logic       irq;
  logic [31:0] rv;
  int n_cmp = 0;
  int n_err = 0;

`ifdef PIO_GEN2_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  pio_gen2_if bus();

  pio_gen2 #(
    .WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ex(input logic [31:0] v);
    return IRQ_EN ? v : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
  endtask

  // Drives a write for exactly one rising edge, returns at the following negedge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    #1;
    v = bus.readdata;
    idle();
  endtask

  initial begin
    idle();
    reset   = 1'b1;
    in_port = 8'h00;
    cyc(2);
    chk("rst_out", 32'(out_port), 32'hA5);
    chk("rst_oe",  32'(oe), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    rd(3'd1, rv); chk("rst_rd_dir", rv, 32'h0);
    rd(3'd2, rv); chk("rst_rd_mask", rv, 32'h0);
    rd(3'd3, rv); chk("rst_rd_cap", rv, 32'h0);
    rd(3'd0, rv); chk("rst_rd_data", rv, 32'h0);

    // Back-to-back DATA / OUTSET / OUTCLR
    wr(3'd0, 32'h0F); chk("out_data", 32'(out_port), 32'h0F);
    wr(3'd4, 32'hF0); chk("out_set", 32'(out_port), 32'hFF);
    wr(3'd5, 32'h11); chk("out_clr", 32'(out_port), 32'hEE);
    rd(3'd4, rv); chk("rd_outset", rv, 32'h0);
    rd(3'd5, rv); chk("rd_outclr", rv, 32'h0);

    // Mixed direction read-back and input latency
    in_port = 8'h03;
    wr(3'd1, 32'hF0);
    chk("oe_dir", 32'(oe), 32'hF0);
    rd(3'd0, rv); chk("data_lat1", rv, 32'hE0);
    cyc(1);
    rd(3'd0, rv); chk("data_mixed", rv, 32'hE3);
    rd(3'd1, rv); chk("rd_dir", rv, 32'hF0);
    cyc(1);
    rd(3'd3, rv); chk("cap_unmasked", rv, ex(32'h03));
    chk("irq_unmasked", 32'(irq), 32'h0);

    // Falling edges are not captured; W1C and reserved writes
    in_port = 8'h00;
    cyc(3);
    rd(3'd3, rv); chk("cap_fall_ign", rv, ex(32'h03));
    wr(3'd3, 32'hFF);
    rd(3'd3, rv); chk("cap_w1c", rv, 32'h0);
    wr(3'd6, 32'hFF);
    chk("rsvd_out", 32'(out_port), 32'hEE);
    chk("rsvd_oe",  32'(oe), 32'hF0);
    rd(3'd6, rv); chk("rd_rsvd", rv, 32'h0);

    // Masked rising edge on bit 0 raises irq at edge SYNC_STAGES+1
    wr(3'd2, 32'h01);
    rd(3'd2, rv); chk("rd_mask", rv, ex(32'h01));
    in_port = 8'h01;
    cyc(2);
    chk("irq_early", 32'(irq), 32'h0);
    rd(3'd3, rv); chk("cap_early", rv, 32'h0);
    cyc(1);
    chk("irq_edge", 32'(irq), ex(32'h1));
    rd(3'd3, rv); chk("cap_edge", rv, ex(32'h01));
    wr(3'd3, 32'h01);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(3'd3, rv); chk("cap_cleared", rv, 32'h0);

    // Pending capture becomes visible when its mask bit is written
    wr(3'd2, 32'h00);
    in_port = 8'h03;
    cyc(3);
    rd(3'd3, rv); chk("cap_bit1", rv, ex(32'h02));
    chk("irq_masked", 32'(irq), 32'h0);
    wr(3'd2, 32'h02);
    chk("irq_unmask", 32'(irq), ex(32'h1));
    wr(3'd3, 32'h02);
    chk("irq_clr2", 32'(irq), 32'h0);

    // Edge and clear on the same cycle: set wins
    wr(3'd2, 32'h01);
    in_port = 8'h02; cyc(3);
    in_port = 8'h03; cyc(3);
    chk("irq_pre_sw", 32'(irq), ex(32'h1));
    in_port = 8'h02; cyc(3);
    in_port = 8'h03; cyc(2);
    wr(3'd3, 32'h01);
    rd(3'd3, rv); chk("cap_set_wins", rv, ex(32'h01));
    chk("irq_set_wins", 32'(irq), ex(32'h1));
    wr(3'd3, 32'h01);
    rd(3'd3, rv); chk("cap_after_sw", rv, 32'h0);
    chk("irq_after_sw", 32'(irq), 32'h0);

    // Asynchronous reset with everything captured
    wr(3'd2, 32'hFF);
    in_port = 8'h00; cyc(3);
    wr(3'd3, 32'hFF);
    in_port = 8'hFF; cyc(3);
    rd(3'd3, rv); chk("cap_all", rv, ex(32'hFF));
    chk("irq_all", 32'(irq), ex(32'h1));
    #2 reset = 1'b1;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_out", 32'(out_port), 32'hA5);
    chk("arst_oe",  32'(oe), 32'h00);
    rd(3'd3, rv); chk("arst_cap", rv, 32'h0);
    rd(3'd2, rv); chk("arst_mask", rv, 32'h0);
    rd(3'd0, rv); chk("arst_data", rv, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(4);
    chk("post_rst_irq", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end
endmodule
